// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_set_ctrl (with helper clock_set_ctrl_debounce)
// Purpose  : Front-panel controller for setting a real-time clock/calendar.
//            Three raw active-low pushbuttons are synchronized and debounced
//            into single-cycle press events. Those events drive an edit FSM
//            that selects a time field or a date field. The FSM issues
//            one-cycle increment/decrement commands to the counter, blinks
//            the selected field and falls back to free-run after an idle
//            timeout.
// Ports    : clk            - system clock, rising edge
//            rst_n          - asynchronous active-low reset
//            mode           - 0 = time fields, 1 = date fields
//            butt_change    - raw active-low "next field" button
//            butt_increase  - raw active-low "increment" button
//            butt_decrease  - raw active-low "decrement" button
//            run_en         - counter free-run enable (1 only when not editing)
//            field_sel[2:0] - 0 none, 1 sec, 2 min, 3 hour, 4 day, 5 month,
//                             6 year
//            adj_inc        - one-cycle increment command for field_sel
//            adj_dec        - one-cycle decrement command for field_sel
//            blink          - display enable for the selected field's digits
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Per-button synchronizer + debouncer. It emits a one-cycle press pulse when
// the debounced level goes from released (1) to pressed (0).
// ----------------------------------------------------------------------------
module clock_set_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_level;
  logic               r_press;
  logic [c_cnt_w-1:0] r_cnt;

  // Two-flop synchronizer; idles at the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // The counter tallies consecutive samples that disagree with the accepted
  // level. Any agreeing sample restarts it. The D-th disagreeing sample
  // updates the level. The press pulse is registered together with the level
  // so that the FSM consumes it on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;

endmodule

// ----------------------------------------------------------------------------
// Top level: edit FSM, adjust commands, blink generator and idle timeout.
// ----------------------------------------------------------------------------
module clock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_HALF      = 12500000,
  parameter int IDLE_TIMEOUT    = 500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic       butt_change,
  input  logic       butt_increase,
  input  logic       butt_decrease,
  output logic       run_en,
  output logic [2:0] field_sel,
  output logic       adj_inc,
  output logic       adj_dec,
  output logic       blink
);

  // State codes equal the field_sel code of the field being edited, so
  // the field_sel output is a gated copy of the state register.
  localparam logic [2:0] c_st_run       = 3'd0;
  localparam logic [2:0] c_st_set_sec   = 3'd1;
  localparam logic [2:0] c_st_set_min   = 3'd2;
  localparam logic [2:0] c_st_set_hour  = 3'd3;
  localparam logic [2:0] c_st_set_day   = 3'd4;
  localparam logic [2:0] c_st_set_month = 3'd5;
  localparam logic [2:0] c_st_set_year  = 3'd6;

  localparam int c_blink_w = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int c_idle_w  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_HALF - 1);
  localparam logic [c_idle_w-1:0]  c_idle_last  = c_idle_w'(IDLE_TIMEOUT - 1);

  // Button index: 0 change, 1 increase, 2 decrease.
  logic [2:0] w_btn_raw;
  logic [2:0] w_press;

  logic       w_chg_evt;
  logic       w_inc_evt;
  logic       w_dec_evt;
  logic       w_any_press;

  logic [2:0] r_state;
  logic [2:0] w_state_next;
  logic       w_time_grp;
  logic       w_date_grp;
  logic       w_in_edit;
  logic       w_mode_mismatch;
  logic       w_timeout;
  logic       w_state_change;
  logic       w_adj_ok;

  logic                 r_adj_inc;
  logic                 r_adj_dec;
  logic                 r_blink;
  logic [c_blink_w-1:0] r_blink_cnt;
  logic [c_idle_w-1:0]  r_idle;

  assign w_btn_raw = {butt_decrease, butt_increase, butt_change};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    clock_set_ctrl_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(w_btn_raw[gi]),
      .press  (w_press[gi])
    );
  end

  assign w_chg_evt   = w_press[0];
  assign w_inc_evt   = w_press[1];
  assign w_dec_evt   = w_press[2];
  assign w_any_press = |w_press;

  // --------------------------------------------------------------------------
  // State classification
  // --------------------------------------------------------------------------
  always_comb begin
    w_time_grp = (r_state == c_st_set_hour) || (r_state == c_st_set_min) ||
                 (r_state == c_st_set_sec);
    w_date_grp = (r_state == c_st_set_day) || (r_state == c_st_set_month) ||
                 (r_state == c_st_set_year);
  end

  assign w_in_edit       = w_time_grp | w_date_grp;
  // Flipping mode while editing abandons the edit.
  assign w_mode_mismatch = (w_time_grp & mode) | (w_date_grp & ~mode);
  // A press on the terminal idle cycle restarts the idle count instead.
  assign w_timeout       = w_in_edit & ~w_any_press & (r_idle == c_idle_last);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_run;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. Priority: unknown code, mode mismatch, change
  // event, idle timeout.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (!w_in_edit && (r_state != c_st_run)) begin
      w_state_next = c_st_run;
    end else if (w_mode_mismatch) begin
      w_state_next = c_st_run;
    end else if (w_chg_evt) begin
      case (r_state)
        c_st_run:       w_state_next = mode ? c_st_set_day : c_st_set_hour;
        c_st_set_hour:  w_state_next = c_st_set_min;
        c_st_set_min:   w_state_next = c_st_set_sec;
        c_st_set_sec:   w_state_next = c_st_run;
        c_st_set_day:   w_state_next = c_st_set_month;
        c_st_set_month: w_state_next = c_st_set_year;
        c_st_set_year:  w_state_next = c_st_run;
        default:        w_state_next = c_st_run;
      endcase
    end else if (w_timeout) begin
      w_state_next = c_st_run;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    run_en    = (r_state == c_st_run);
    field_sel = w_in_edit ? r_state : 3'd0;
  end

  assign w_state_change = (w_state_next != r_state);

  // --------------------------------------------------------------------------
  // Adjust commands. These are only issued while staying in a valid edit
  // state. A coincident change event wins, and simultaneous increase and
  // decrease cancel each other, so both commands can never be high together.
  // --------------------------------------------------------------------------
  assign w_adj_ok = w_in_edit & ~w_mode_mismatch & ~w_chg_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adj_inc <= 1'b0;
      r_adj_dec <= 1'b0;
    end else begin
      r_adj_inc <= w_adj_ok & w_inc_evt & ~w_dec_evt;
      r_adj_dec <= w_adj_ok & w_dec_evt & ~w_inc_evt;
    end
  end

  assign adj_inc = r_adj_inc;
  assign adj_dec = r_adj_dec;

  // --------------------------------------------------------------------------
  // Blink generator: held on outside edit states and restarted in the "on"
  // phase on every state change.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink     <= 1'b1;
      r_blink_cnt <= '0;
    end else if (w_state_change || !w_in_edit) begin
      r_blink     <= 1'b1;
      r_blink_cnt <= '0;
    end else if (r_blink_cnt == c_blink_last) begin
      r_blink     <= ~r_blink;
      r_blink_cnt <= '0;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign blink = r_blink;

  // --------------------------------------------------------------------------
  // Idle counter: counts edge-to-edge cycles spent in an edit state without a
  // press. It saturates at its terminal value, which is the cycle that
  // triggers the timeout.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (!w_in_edit || w_any_press || w_state_change) begin
      r_idle <= '0;
    end else if (r_idle != c_idle_last) begin
      r_idle <= r_idle + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_set_ctrl
// Purpose  : Self-checking bench for clock_set_ctrl. A behavioural model
//            derives every output from the field order, the sliding debounce
//            window and elapsed-cycle arithmetic. Directed scenarios pin the
//            model with literal expectations, and a randomized phase follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_set_ctrl;

  localparam int DB = 4;
  localparam int BH = 8;
  localparam int IT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic       butt_change = 1'b1;
  logic       butt_increase = 1'b1;
  logic       butt_decrease = 1'b1;
  logic       run_en;
  logic [2:0] field_sel;
  logic       adj_inc;
  logic       adj_dec;
  logic       blink;

  int n_cmp = 0;
  int n_bad = 0;
  int n_inc_pulses = 0;
  int n_dec_pulses = 0;

  clock_set_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .BLINK_HALF     (BH),
    .IDLE_TIMEOUT   (IT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .butt_change  (butt_change),
    .butt_increase(butt_increase),
    .butt_decrease(butt_decrease),
    .run_en       (run_en),
    .field_sel    (field_sel),
    .adj_inc      (adj_inc),
    .adj_dec      (adj_dec),
    .blink        (blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  int m_field;          // 0 = run, otherwise field code being edited
  bit m_inc, m_dec;
  int cyc, last_change, last_clear;
  bit m_d1[3], m_d2[3], m_lvl[3], m_pr[3];
  bit hist[3][DB];      // last DB synchronized samples, newest in [0]

  // Field visiting order: time 3->2->1->run, date 4->5->6->run.
  function automatic int next_field(input int f, input bit md);
    case (f)
      0:       return md ? 4 : 3;
      3:       return 2;
      2:       return 1;
      4:       return 5;
      5:       return 6;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_field = 0;
    m_inc = 0;
    m_dec = 0;
    last_change = cyc;
    last_clear = cyc;
    for (int b = 0; b < 3; b++) begin
      m_d1[b] = 1; m_d2[b] = 1; m_lvl[b] = 1; m_pr[b] = 0;
      for (int j = 0; j < DB; j++) hist[b][j] = 1;
    end
  endtask

  task automatic model_step();
    bit chg, inc, dec, edit, mism, all_diff, s;
    bit raw[3];
    int nf;
    cyc++;
    chg = m_pr[0]; inc = m_pr[1]; dec = m_pr[2];
    edit = (m_field != 0);
    mism = edit && (mode != (m_field >= 4));
    nf = m_field;
    m_inc = 0; m_dec = 0;
    if (mism) nf = 0;
    else if (chg) nf = next_field(m_field, mode);
    else if (edit && !inc && !dec && (cyc - last_clear) >= IT) nf = 0;
    else if (edit && (inc != dec)) begin
      m_inc = inc; m_dec = dec;
    end
    if (chg || inc || dec || (!edit && nf != 0)) last_clear = cyc;
    if (nf != m_field) last_change = cyc;
    m_field = nf;
    raw[0] = butt_change; raw[1] = butt_increase; raw[2] = butt_decrease;
    for (int b = 0; b < 3; b++) begin
      s = m_d2[b];
      m_d2[b] = m_d1[b];
      m_d1[b] = raw[b];
      for (int j = DB - 1; j > 0; j--) hist[b][j] = hist[b][j-1];
      hist[b][0] = s;
      all_diff = 1;
      for (int j = 0; j < DB; j++) if (hist[b][j] == m_lvl[b]) all_diff = 0;
      m_pr[b] = 0;
      if (all_diff) begin
        m_lvl[b] = s;
        m_pr[b] = (s == 0);
      end
    end
  endtask

  initial begin
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    int exp_blink;
    forever begin
      @(negedge clk);
      if (adj_inc) n_inc_pulses++;
      if (adj_dec) n_dec_pulses++;
      exp_blink = (m_field == 0) ? 1 : ((((cyc - last_change) / BH) % 2) == 0 ? 1 : 0);
      chk("run_en", int'(run_en), (m_field == 0) ? 1 : 0);
      chk("field_sel", int'(field_sel), m_field);
      chk("adj_inc", int'(adj_inc), int'(m_inc));
      chk("adj_dec", int'(adj_dec), int'(m_dec));
      chk("blink", int'(blink), exp_blink);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       butt_change = v;
      1:       butt_increase = v;
      default: butt_decrease = v;
    endcase
  endtask

  task automatic press_hold(input int b, input int low, input int gap);
    @(negedge clk);
    set_btn(b, 1'b0);
    repeat (low) @(negedge clk);
    set_btn(b, 1'b1);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int base_inc, base_dec, mask, len;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_run_en", int'(run_en), 1);
    chk("rst_field", int'(field_sel), 0);
    chk("rst_blink", int'(blink), 1);
    chk("rst_adj", int'({adj_inc, adj_dec}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Time edit entry: press accepted on the 7th edge after the first low
    // sample (t+2+DB with t the first sampling edge)
    mode = 1'b0;
    @(negedge clk);
    butt_change = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("chg_before_t6", int'(field_sel), 0);
    @(posedge clk);
    #1 chk("chg_at_t6_field", int'(field_sel), 3);
    chk("chg_at_t6_run_en", int'(run_en), 0);
    repeat (4) @(negedge clk);
    butt_change = 1'b1;
    repeat (10) @(negedge clk);
    press_hold(0, 10, 10);
    chk("to_min", int'(field_sel), 2);
    press_hold(0, 10, 10);
    chk("to_sec", int'(field_sel), 1);
    press_hold(0, 10, 10);
    chk("back_run_field", int'(field_sel), 0);
    chk("back_run_en", int'(run_en), 1);

    // Glitch rejection and single increment in SET_MIN
    press_hold(0, 10, 10);
    press_hold(0, 10, 10);
    chk("in_min", int'(field_sel), 2);
    base_inc = n_inc_pulses;
    press_hold(1, 3, 10);
    chk("glitch_no_inc", n_inc_pulses - base_inc, 0);
    press_hold(1, 10, 10);
    chk("held_one_inc", n_inc_pulses - base_inc, 1);
    chk("min_kept", int'(field_sel), 2);

    // Mode mismatch leaves edit; date edit with simultaneous inc/dec
    @(negedge clk);
    mode = 1'b1;
    @(posedge clk);
    #1 chk("mismatch_time", int'(field_sel), 0);
    press_hold(0, 10, 10);
    chk("in_day", int'(field_sel), 4);
    base_inc = n_inc_pulses;
    base_dec = n_dec_pulses;
    @(negedge clk);
    butt_increase = 1'b0;
    butt_decrease = 1'b0;
    repeat (10) @(negedge clk);
    butt_increase = 1'b1;
    butt_decrease = 1'b1;
    repeat (10) @(negedge clk);
    chk("both_no_inc", n_inc_pulses - base_inc, 0);
    chk("both_no_dec", n_dec_pulses - base_dec, 0);
    @(negedge clk);
    mode = 1'b0;
    @(posedge clk);
    #1 chk("mismatch_date_field", int'(field_sel), 0);
    chk("mismatch_date_run", int'(run_en), 1);

    // SET_YEAR blink cadence and idle timeout
    @(negedge clk);
    mode = 1'b1;
    press_hold(0, 10, 10);
    press_hold(0, 10, 10);
    @(negedge clk);
    butt_change = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("year_entry", int'(field_sel), 6);
    chk("year_blink_e0", int'(blink), 1);
    butt_change = 1'b1;
    repeat (7) @(posedge clk);
    #1 chk("blink_e7", int'(blink), 1);
    @(posedge clk);
    #1 chk("blink_e8", int'(blink), 0);
    repeat (8) @(posedge clk);
    #1 chk("blink_e16", int'(blink), 1);
    repeat (47) @(posedge clk);
    #1 chk("idle_e63", int'(field_sel), 6);
    @(posedge clk);
    #1 chk("idle_e64_field", int'(field_sel), 0);
    chk("idle_e64_run", int'(run_en), 1);

    // Change beats increase; asynchronous reset mid-edit
    @(negedge clk);
    mode = 1'b0;
    press_hold(0, 10, 10);
    base_inc = n_inc_pulses;
    @(negedge clk);
    butt_change = 1'b0;
    butt_increase = 1'b0;
    repeat (10) @(negedge clk);
    butt_change = 1'b1;
    butt_increase = 1'b1;
    repeat (10) @(negedge clk);
    chk("chg_prio_field", int'(field_sel), 2);
    chk("chg_prio_no_inc", n_inc_pulses - base_inc, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    butt_change = 1'b0;
    #1 chk("async_rst_field", int'(field_sel), 0);
    chk("async_rst_run_en", int'(run_en), 1);
    chk("async_rst_blink", int'(blink), 1);
    chk("async_rst_adj", int'({adj_inc, adj_dec}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("post_rst_before", int'(field_sel), 0);
    @(posedge clk);
    #1 chk("post_rst_press", int'(field_sel), 3);
    @(negedge clk);
    butt_change = 1'b1;
    repeat (10) @(negedge clk);

    // Randomized phase against the model
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 15))
        0: begin
          @(negedge clk);
          mode = ~mode;
        end
        1: repeat (70) @(negedge clk);
        default: begin
          mask = $urandom_range(1, 7);
          len = $urandom_range(1, 12);
          @(negedge clk);
          for (int b = 0; b < 3; b++) if (mask[b]) set_btn(b, 1'b0);
          repeat (len) @(negedge clk);
          butt_change = 1'b1;
          butt_increase = 1'b1;
          butt_decrease = 1'b1;
          repeat ($urandom_range(0, 10)) @(negedge clk);
        end
      endcase
    end

    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
